// File: rtl/ascon_regs_mc.sv
// Multi-channel register front-end for the ASCON permutation core.
// Channels queue start requests; a round-robin FSM issues them to one shared core.
module ascon_regs_mc #(
    parameter int DATA_W     = 32,
    parameter int STATE_BITS = 320,
    parameter int NUM_CH     = 2,
    parameter int ADDR_W     = 8,
    parameter int ROUND_W    = 4,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  reg_valid_i,
    input  logic                  reg_write_i,
    input  logic [ADDR_W-1:0]     reg_addr_i,
    input  logic [DATA_W-1:0]     reg_wdata_i,
    output logic                  reg_ready_o,
    output logic [DATA_W-1:0]     reg_rdata_o,
    output logic                  reg_error_o,
    output logic                  core_valid_o,
    input  logic                  core_ready_i,
    output logic [CH_W-1:0]       core_ch_o,
    output logic [ROUND_W-1:0]    core_rounds_o,
    output logic [STATE_BITS-1:0] core_state_o,
    input  logic                  core_done_i,
    input  logic [STATE_BITS-1:0] core_state_i,
    output logic                  irq_o
);
    localparam int W = STATE_BITS / DATA_W;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} fsm_e;

    fsm_e fsm_q, fsm_d;
    logic [NUM_CH-1:0][STATE_BITS-1:0] state_q, state_d;
    logic [NUM_CH-1:0][ROUND_W-1:0]    rounds_q, rounds_d;
    logic [NUM_CH-1:0] ie_q, ie_d, pend_q, pend_d, fly_q, fly_d;
    logic [NUM_CH-1:0] done_q, done_d, err_q, err_d;
    logic [CH_W-1:0]   grant_q, grant_d, last_q, last_d;

    logic [ADDR_W-3:0] idx;
    logic [3:0]        off;
    int                ch_n;
    int                wi;
    logic [CH_W-1:0]   ci;
    logic [CH_W-1:0]   cand;
    logic              hit;
    logic              found;
    logic [NUM_CH-1:0] busy;
    logic              unused_ok;

    assign idx       = reg_addr_i[ADDR_W-1:2];
    assign off       = idx[3:0];
    assign ch_n      = int'(idx >> 4);
    assign wi        = int'(off) - 2;
    assign ci        = CH_W'(ch_n);
    assign hit       = (ch_n < NUM_CH) && (int'(off) <= W + 1);
    assign busy      = pend_q | fly_q;
    assign unused_ok = ^reg_addr_i[1:0];

    always_comb begin
        state_d     = state_q;
        rounds_d    = rounds_q;
        ie_d        = ie_q;
        pend_d      = pend_q;
        fly_d       = fly_q;
        done_d      = done_q;
        err_d       = err_q;
        grant_d     = grant_q;
        last_d      = last_q;
        fsm_d       = fsm_q;
        reg_rdata_o = '0;
        reg_error_o = 1'b0;
        found       = 1'b0;
        cand        = '0;

        if (reg_valid_i) begin
            if (!hit) begin
                reg_error_o = 1'b1;
            end else if (off == 4'd0) begin
                reg_rdata_o[1]            = ie_q[ci];
                reg_rdata_o[8 +: ROUND_W] = rounds_q[ci];
                if (reg_write_i) begin
                    if (reg_wdata_i[0] && busy[ci]) begin
                        reg_error_o = 1'b1;
                        err_d[ci]   = 1'b1;
                    end else begin
                        ie_d[ci] = reg_wdata_i[1];
                        // rounds frozen while the request is outstanding
                        if (!busy[ci]) rounds_d[ci] = reg_wdata_i[8 +: ROUND_W];
                        if (reg_wdata_i[0]) begin
                            pend_d[ci] = 1'b1;
                            done_d[ci] = 1'b0;
                        end
                    end
                end
            end else if (off == 4'd1) begin
                reg_rdata_o[2:0] = {err_q[ci], done_q[ci], busy[ci]};
                if (reg_write_i) begin
                    done_d[ci] = done_q[ci] & ~reg_wdata_i[1];
                    err_d[ci]  = err_q[ci] & ~reg_wdata_i[2];
                end
            end else begin
                reg_rdata_o = state_q[ci][wi*DATA_W +: DATA_W];
                if (reg_write_i) begin
                    if (busy[ci]) begin
                        reg_error_o = 1'b1;
                        err_d[ci]   = 1'b1;
                    end else begin
                        state_d[ci][wi*DATA_W +: DATA_W] = reg_wdata_i;
                    end
                end
            end
        end

        // hardware updates come last so a set beats a same-cycle W1C
        unique case (fsm_q)
            IDLE: begin
                for (int i = 1; i <= NUM_CH; i++) begin
                    cand = CH_W'((int'(last_q) + i) % NUM_CH);
                    if (!found && pend_q[cand]) begin
                        found   = 1'b1;
                        grant_d = cand;
                    end
                end
                if (found) begin
                    last_d         = grant_d;
                    pend_d[grant_d] = 1'b0;
                    fly_d[grant_d]  = 1'b1;
                    fsm_d          = ISSUE;
                end
            end
            ISSUE: begin
                if (core_ready_i) fsm_d = WAIT;
            end
            WAIT: begin
                if (core_done_i) begin
                    state_d[grant_q] = core_state_i;
                    done_d[grant_q]  = 1'b1;
                    fly_d[grant_q]   = 1'b0;
                    fsm_d            = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fsm_q    <= IDLE;
            state_q  <= '0;
            rounds_q <= '0;
            ie_q     <= '0;
            pend_q   <= '0;
            fly_q    <= '0;
            done_q   <= '0;
            err_q    <= '0;
            grant_q  <= '0;
            last_q   <= CH_W'(NUM_CH - 1);
        end else begin
            fsm_q    <= fsm_d;
            state_q  <= state_d;
            rounds_q <= rounds_d;
            ie_q     <= ie_d;
            pend_q   <= pend_d;
            fly_q    <= fly_d;
            done_q   <= done_d;
            err_q    <= err_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
        end
    end

    assign reg_ready_o   = 1'b1;
    assign core_valid_o  = (fsm_q == ISSUE);
    assign core_ch_o     = grant_q;
    assign core_rounds_o = rounds_q[grant_q];
    assign core_state_o  = state_q[grant_q];
    assign irq_o         = |(done_q & ie_q);
endmodule

// File: tb/tb_ascon_regs_mc.sv
// Bench for ascon_regs_mc: scoreboard of expected core requests plus register checks.
module tb_ascon_regs_mc;
    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         reg_valid_i = 1'b0;
    logic         reg_write_i = 1'b0;
    logic [7:0]   reg_addr_i = '0;
    logic [31:0]  reg_wdata_i = '0;
    logic         reg_ready_o;
    logic [31:0]  reg_rdata_o;
    logic         reg_error_o;
    logic         core_valid_o;
    logic         core_ready_i = 1'b0;
    logic [0:0]   core_ch_o;
    logic [3:0]   core_rounds_o;
    logic [319:0] core_state_o;
    logic         core_done_i = 1'b0;
    logic [319:0] core_state_i = '0;
    logic         irq_o;

    ascon_regs_mc dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .reg_valid_i(reg_valid_i), .reg_write_i(reg_write_i),
        .reg_addr_i(reg_addr_i), .reg_wdata_i(reg_wdata_i),
        .reg_ready_o(reg_ready_o), .reg_rdata_o(reg_rdata_o),
        .reg_error_o(reg_error_o),
        .core_valid_o(core_valid_o), .core_ready_i(core_ready_i),
        .core_ch_o(core_ch_o), .core_rounds_o(core_rounds_o),
        .core_state_o(core_state_o), .core_done_i(core_done_i),
        .core_state_i(core_state_i), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int           ch;
        logic [3:0]   rounds;
        logic [319:0] state;
    } req_t;

    req_t         exp_q[$];
    logic [319:0] mdl_state[2];
    int           n_vec = 0;
    int           n_bad = 0;
    int           req_cnt = 0;

    always @(posedge clk_i)
        if (core_valid_o && core_ready_i) req_cnt <= req_cnt + 1;

    task automatic chk(input string tag, input logic [319:0] got,
                       input logic [319:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ra(input int ch, input int off);
        return 8'((ch * 16 + off) * 4);
    endfunction

    task automatic bus_wr(input logic [7:0] a, input logic [31:0] d,
                          output logic e);
        @(negedge clk_i);
        reg_valid_i = 1'b1; reg_write_i = 1'b1;
        reg_addr_i = a; reg_wdata_i = d;
        #1 e = reg_error_o;
        @(posedge clk_i);
        #1 reg_valid_i = 1'b0; reg_write_i = 1'b0;
    endtask

    task automatic bus_rd(input logic [7:0] a, output logic [31:0] d,
                          output logic e);
        @(negedge clk_i);
        reg_valid_i = 1'b1; reg_write_i = 1'b0; reg_addr_i = a;
        #1 d = reg_rdata_o; e = reg_error_o;
        @(posedge clk_i);
        #1 reg_valid_i = 1'b0;
    endtask

    task automatic start(input int ch, input logic [31:0] ctrl);
        logic e;
        req_t r;
        bus_wr(ra(ch, 0), ctrl, e);
        chk("start_err", e, 0);
        r.ch = ch; r.rounds = ctrl[11:8]; r.state = mdl_state[ch];
        exp_q.push_back(r);
    endtask

    task automatic rd_chk(input string tag, input int ch, input int off,
                          input logic [31:0] exp, input logic exp_e);
        logic [31:0] d;
        logic e;
        bus_rd(ra(ch, off), d, e);
        chk(tag, d, exp);
        chk({tag, "_e"}, e, exp_e);
    endtask

    // mode 0 normal, 1 W1C done alongside the done pulse, 2 reset during WAIT
    task automatic serve(input int mode);
        req_t e;
        int k;
        if (exp_q.size() == 0) begin
            chk("sb_underflow", 1, 0);
            return;
        end
        e = exp_q.pop_front();
        k = 0;
        while (!core_valid_o && k < 50) begin
            @(negedge clk_i);
            k++;
        end
        chk("req_seen", core_valid_o, 1);
        if (!core_valid_o) return;
        chk("core_ch", core_ch_o, e.ch);
        chk("core_rounds", core_rounds_o, e.rounds);
        chk("core_state", core_state_o, e.state);
        repeat (3) @(negedge clk_i);
        chk("valid_hold", core_valid_o, 1);
        chk("state_hold", core_state_o, e.state);
        core_ready_i = 1'b1;
        @(negedge clk_i);
        core_ready_i = 1'b0;
        chk("valid_drop", core_valid_o, 0);
        repeat (2) @(negedge clk_i);
        if (mode == 2) begin
            rst_i = 1'b1;
            #1;
            chk("rst_valid", core_valid_o, 0);
            chk("rst_irq", irq_o, 0);
            chk("rst_state_o", core_state_o, 0);
            chk("rst_rounds_o", core_rounds_o, 0);
            @(negedge clk_i);
            rst_i = 1'b0;
            core_done_i = 1'b1;
            core_state_i = '1;
            @(negedge clk_i);
            core_done_i = 1'b0;
            mdl_state[0] = '0;
            mdl_state[1] = '0;
            return;
        end
        core_done_i = 1'b1;
        core_state_i = ~e.state;
        if (mode == 1) begin
            reg_valid_i = 1'b1; reg_write_i = 1'b1;
            reg_addr_i = ra(e.ch, 1); reg_wdata_i = 32'h2;
        end
        @(negedge clk_i);
        core_done_i = 1'b0;
        reg_valid_i = 1'b0; reg_write_i = 1'b0;
        mdl_state[e.ch] = ~e.state;
    endtask

    initial begin
        logic e;
        logic [31:0] d;
        int rc;
        mdl_state[0] = '0;
        mdl_state[1] = '0;

        repeat (2) @(negedge clk_i);
        chk("rst_valid0", core_valid_o, 0);
        chk("rst_irq0", irq_o, 0);
        chk("rst_rdata0", reg_rdata_o, 0);
        chk("rst_ready", reg_ready_o, 1);
        rd_chk("rst_status", 0, 1, 0, 0);
        rd_chk("rst_ctrl", 0, 0, 0, 0);
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < 10; i++) begin
            bus_wr(ra(0, 2 + i), 32'h1000 + i, e);
            chk("wr0_err", e, 0);
            mdl_state[0][i*32 +: 32] = 32'h1000 + i;
        end
        start(0, 32'h0C01);
        chk("lat_pending", core_valid_o, 0);
        @(posedge clk_i);
        #1 chk("lat_issue", core_valid_o, 1);
        serve(0);
        rd_chk("t1_status", 0, 1, 32'h2, 0);
        for (int i = 0; i < 10; i++)
            rd_chk("t1_word", 0, 2 + i, ~(32'h1000 + i), 0);

        for (int i = 0; i < 10; i++) begin
            bus_wr(ra(1, 2 + i), 32'h2000 + i, e);
            mdl_state[1][i*32 +: 32] = 32'h2000 + i;
        end
        for (int r = 0; r < 2; r++) begin
            start(0, 32'h0C01);
            start(1, 32'h0301);
            serve(0);
            serve(0);
        end

        start(1, 32'h0501);
        bus_wr(ra(1, 2), 32'hDEAD, e);
        chk("busy_wr_err", e, 1);
        rd_chk("busy_rd", 1, 2, mdl_state[1][31:0], 0);
        bus_wr(ra(1, 0), 32'h0501, e);
        chk("busy_start_err", e, 1);
        bus_wr(ra(1, 0), 32'h0002, e);
        chk("ie_only_err", e, 0);
        rd_chk("busy_status", 1, 1, 32'h5, 0);
        rc = req_cnt;
        serve(0);
        repeat (5) @(negedge clk_i);
        chk("no_extra_req", req_cnt, rc + 1);
        chk("irq_ch1", irq_o, 1);
        rd_chk("ch1_status", 1, 1, 32'h6, 0);
        bus_wr(ra(1, 1), 32'h6, e);
        rd_chk("ch1_w1c", 1, 1, 32'h0, 0);
        chk("irq_ch1_off", irq_o, 0);

        rd_chk("bad_ch_rd", 3, 2, 0, 1);
        bus_wr(ra(3, 2), 32'h55, e);
        chk("bad_ch_wr", e, 1);
        rd_chk("bad_off_rd", 0, 15, 0, 1);
        rd_chk("bad_off12", 0, 12, 0, 1);
        bus_wr(ra(0, 15), 32'h77, e);
        chk("bad_off_wr", e, 1);
        rd_chk("no_side_w0", 0, 2, mdl_state[0][31:0], 0);
        rd_chk("no_side_st", 0, 1, 32'h2, 0);

        start(0, 32'h0C03);
        chk("done_clr_irq", irq_o, 0);
        serve(0);
        #1 chk("irq_on", irq_o, 1);
        start(0, 32'h0C03);
        chk("irq_restart", irq_o, 0);
        serve(1);
        rd_chk("set_wins", 0, 1, 32'h2, 0);
        chk("irq_kept", irq_o, 1);
        bus_wr(ra(0, 1), 32'h2, e);
        rd_chk("w1c_alone", 0, 1, 32'h0, 0);
        chk("irq_clr", irq_o, 0);

        start(0, 32'h0C03);
        serve(2);
        repeat (3) @(negedge clk_i);
        chk("post_rst_valid", core_valid_o, 0);
        rd_chk("post_rst_w0", 0, 2, 0, 0);
        rd_chk("post_rst_st", 0, 1, 0, 0);
        rd_chk("post_rst_ctrl", 0, 0, 0, 0);
        chk("sb_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 want 0");
        $fatal(1, "timeout");
    end
endmodule
